// File: rtl/iir_ctrl.sv
// Sample-rate sequencer for an external IIR core: flushes the filter with zeros after
// start or coefficient change, then paces input samples and tags results for output.
module iir_ctrl #(
    parameter int DW      = 16,
    parameter int FW      = 16,
    parameter int LAT     = 2,
    parameter int FLUSH_N = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 run_i,
    input  logic [15:0]          div_cfg_i,
    input  logic                 cfg_wr_i,
    input  logic [31:0]          cfg_index_i,
    input  logic                 s_valid_i,
    input  logic signed [DW-1:0] s_data_i,
    output logic                 s_ready_o,
    output logic                 iir_en_o,
    output logic signed [DW-1:0] iir_din_o,
    output logic [31:0]          iir_index_o,
    input  logic signed [DW-1:0] iir_dout_i,
    output logic                 m_valid_o,
    output logic signed [DW-1:0] m_data_o,
    output logic                 busy_o,
    output logic [15:0]          underrun_cnt_o
);

    // state | meaning
    // IDLE  | filter stopped, waiting for run
    // FLUSH | feeding FLUSH_N zero samples to settle the IIR history
    // RUN   | passing input samples on every tick
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_FLUSH = 3'b010,
        ST_RUN   = 3'b100
    } state_e;

    localparam int FCW = $clog2(FLUSH_N + 1);

    // FW belongs to the companion IIR instance; only its range is sanity-checked here.
    if (FW < 1 || LAT < 1 || FLUSH_N < 1) begin : g_bad_params
        $error("iir_ctrl: FW, LAT and FLUSH_N must all be >= 1");
    end

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [FCW-1:0]        flush_q, flush_d;
    logic signed [DW-1:0]  din_q, din_d;
    logic [31:0]           idx_q, idx_d;
    logic [15:0]           udr_q, udr_d;
    logic signed [DW-1:0]  mdata_q;
    logic [LAT-1:0]        tag_en_q, tag_en_d;
    logic [LAT-1:0]        tag_keep_q, tag_keep_d;
    logic                  tick;
    logic                  s_ready;
    logic                  iir_en;

    // Free-running sample divider; a lowered div_cfg wraps without a tick.
    assign tick  = (cnt_q == div_cfg_i);
    assign cnt_d = (cnt_q >= div_cfg_i) ? 16'd0 : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        din_d   = din_q;
        udr_d   = udr_q;
        s_ready = 1'b0;
        iir_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    state_d = ST_FLUSH;
                    flush_d = FCW'(FLUSH_N);
                end
            end
            ST_FLUSH: begin
                if (!run_i) begin
                    state_d = ST_IDLE;
                end else if (cfg_wr_i) begin
                    flush_d = FCW'(FLUSH_N);
                end else if (tick) begin
                    iir_en  = 1'b1;
                    din_d   = '0;
                    flush_d = flush_q - FCW'(1);
                    if (flush_q == FCW'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!run_i) begin
                    state_d = ST_IDLE;
                end else if (cfg_wr_i) begin
                    // coefficient change takes the tick; the sample slot is dropped uncounted
                    state_d = ST_FLUSH;
                    flush_d = FCW'(FLUSH_N);
                end else if (tick) begin
                    s_ready = 1'b1;
                    if (s_valid_i) begin
                        iir_en = 1'b1;
                        din_d  = s_data_i;
                    end else if (udr_q != 16'hFFFF) begin
                        udr_d = udr_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign idx_d = cfg_wr_i ? cfg_index_i : idx_q;

    // Tag pipeline mirrors the IIR latency so results can be matched to their samples.
    always_comb begin
        tag_en_d      = tag_en_q;
        tag_keep_d    = tag_keep_q;
        tag_en_d[0]   = iir_en;
        tag_keep_d[0] = iir_en && (state_q == ST_RUN);
        for (int i = 1; i < LAT; i++) begin
            tag_en_d[i]   = tag_en_q[i-1];
            tag_keep_d[i] = tag_keep_q[i-1];
        end
    end

    assign m_valid_o = tag_en_q[LAT-1] & tag_keep_q[LAT-1];
    assign m_data_o  = m_valid_o ? iir_dout_i : mdata_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            flush_q    <= '0;
            din_q      <= '0;
            idx_q      <= '0;
            udr_q      <= '0;
            mdata_q    <= '0;
            tag_en_q   <= '0;
            tag_keep_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            din_q      <= din_d;
            idx_q      <= idx_d;
            udr_q      <= udr_d;
            mdata_q    <= m_data_o;
            tag_en_q   <= tag_en_d;
            tag_keep_q <= tag_keep_d;
        end
    end

    assign s_ready_o      = s_ready;
    assign iir_en_o       = iir_en;
    assign iir_din_o      = din_d;
    assign iir_index_o    = idx_q;
    assign busy_o         = (state_q == ST_FLUSH);
    assign underrun_cnt_o = udr_q;

endmodule
